// File: rtl/fp_result_collector_pkg.sv
// Shared constants for the floating-point result collector: result width,
// exception flag width and the fflags-style bit position of each flag.
package fp_result_collector_pkg;

    localparam int FP_RESULT_W = 32;
    localparam int FP_FLAGS_W  = 5;

    // Flag bit positions (fflags order: NV DZ OF UF NX, MSB to LSB)
    localparam int F_INEXACT        = 0;
    localparam int F_UNDERFLOW      = 1;
    localparam int F_OVERFLOW       = 2;
    localparam int F_DIVIDE_BY_ZERO = 3;
    localparam int F_INVALID        = 4;

    typedef logic [FP_FLAGS_W-1:0] fp_flags_t;

endpackage

// File: rtl/fp_result_collector_sync_fifo.sv
// fp_sync_fifo: synchronous FIFO with async active-low reset and a registered
// read port. rd_data always shows the current head one cycle after it was
// written and holds its last value while the FIFO is empty.
module fp_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = rd_data_q;

    // Pointer/occupancy update and next head value for the read register
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(do_wr);
        rd_ptr_d  = rd_ptr_q + AW'(do_rd);
        count_d   = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        rd_data_d = rd_data_q;
        // Only reload when something will be held; an empty FIFO keeps the last value.
        // A write landing in the new head slot is forwarded since mem is not yet updated.
        if (count_d != '0) begin
            if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem[rd_ptr_d];
            end
        end
    end

    // Storage array, write only; no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Control and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: buffers results/flags from the FP pipeline in a small
// FIFO, keeps sticky exception flags and a wrapping retired-operation count.
// Optional per-flag saturating statistics when FP_FLAG_STATS_EN is defined.
module fp_result_collector
    import fp_result_collector_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int FLAGS_W = FP_FLAGS_W,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP_RESULT_W-1:0] in_result,
    input  logic [FLAGS_W-1:0]     in_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP_RESULT_W-1:0] out_result,
    output logic [FLAGS_W-1:0]     out_flags,
    input  logic                   clear_flags,
    output logic [FLAGS_W-1:0]     sticky_flags,
    output logic [CNT_W-1:0]       retired_cnt
`ifdef FP_FLAG_STATS_EN
    ,
    output logic [FLAGS_W*CNT_W-1:0] flag_hist
`endif
);

    localparam int ENTRY_W = FP_RESULT_W + FLAGS_W;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [FLAGS_W-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    fp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({in_result, in_flags}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_result   = head[ENTRY_W-1:FLAGS_W];
    assign out_flags    = head[FLAGS_W-1:0];
    assign sticky_flags = sticky_q;
    assign retired_cnt  = retired_q;

    // Sticky flags: clear first so flags pushed on the clearing edge survive
    always_comb begin
        sticky_d  = clear_flags ? '0 : sticky_q;
        if (push) begin
            sticky_d = sticky_d | in_flags;
        end
        retired_d = retired_q + CNT_W'(pop);
    end

    // Sticky flag and retired counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q  <= '0;
            retired_q <= '0;
        end else begin
            sticky_q  <= sticky_d;
            retired_q <= retired_d;
        end
    end

`ifdef FP_FLAG_STATS_EN
    localparam logic [CNT_W-1:0] HIST_MAX = '1;

    logic [CNT_W-1:0] hist_q [FLAGS_W];
    logic [CNT_W-1:0] hist_d [FLAGS_W];

    for (genvar gi = 0; gi < FLAGS_W; gi++) begin : g_hist
        // Per-flag saturating counter; clear then count so clear+push gives 1
        always_comb begin
            hist_d[gi] = clear_flags ? '0 : hist_q[gi];
            if (push && in_flags[gi] && (hist_d[gi] != HIST_MAX)) begin
                hist_d[gi] = hist_d[gi] + 1'b1;
            end
        end

        // Counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist_q[gi] <= '0;
            end else begin
                hist_q[gi] <= hist_d[gi];
            end
        end

        assign flag_hist[gi*CNT_W +: CNT_W] = hist_q[gi];
    end
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Scoreboard testbench for fp_result_collector. Stimulus pushes expected
// entries and updates the sticky/stats model; a negedge monitor compares.
module tb_fp_result_collector;
    import fp_result_collector_pkg::*;

    localparam int DEPTH = 2;
    localparam int FW    = FP_FLAGS_W;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_result = '0;
    logic [FW-1:0] in_flags = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_result;
    logic [FW-1:0] out_flags;
    logic          clear_flags = 1'b0;
    logic [FW-1:0] sticky_flags;
    logic [CW-1:0] retired_cnt;
`ifdef FP_FLAG_STATS_EN
    logic [FW*CW-1:0] flag_hist;
`endif

    fp_result_collector #(.DEPTH(DEPTH), .FLAGS_W(FW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .clear_flags  (clear_flags),
        .sticky_flags (sticky_flags),
        .retired_cnt  (retired_cnt)
`ifdef FP_FLAG_STATS_EN
        ,
        .flag_hist    (flag_hist)
`endif
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [36:0]   exp_q [$];
    logic [FW-1:0] sticky_m = '0;
    logic [CW-1:0] retired_m = '0;
    int            hist_m [FW];
    bit            mon_en = 1'b0;
    bit            verbose = 1'b1;
    int            pops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus (called at posedge+1); model updated after the edge
    task automatic cycle(input bit v, input logic [31:0] r, input logic [FW-1:0] f,
                         input bit ordy, input bit clr, output bit accepted);
        in_valid    = v;
        in_result   = r;
        in_flags    = f;
        out_ready   = ordy;
        clear_flags = clr;
        accepted    = v && (in_ready === 1'b1);
        @(posedge clk);
        #1;
        if (clr) begin
            sticky_m = '0;
            for (int i = 0; i < FW; i++) hist_m[i] = 0;
        end
        if (accepted) begin
            exp_q.push_back({r, f});
            sticky_m = sticky_m | f;
            for (int i = 0; i < FW; i++)
                if (f[i] && hist_m[i] < 65535) hist_m[i]++;
        end
    endtask

    // Hold an entry upstream until accepted, bounded
    task automatic send(input logic [31:0] r, input logic [FW-1:0] f, input bit ordy, input bit clr);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, r, f, ordy, clr && k == 0, acc);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        cycle(1'b0, 32'd0, '0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
        idle(1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare DUT state with the model and retire head entries
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("sticky", 64'(sticky_flags), 64'(sticky_m));
            check("retired", 64'(retired_cnt), 64'(retired_m));
`ifdef FP_FLAG_STATS_EN
            for (int i = 0; i < FW; i++)
                check("hist", 64'(flag_hist[i*CW +: CW]), 64'(hist_m[i]));
`endif
            if (out_valid && exp_q.size() > 0) begin
                check("head", 64'({out_result, out_flags}), 64'(exp_q[0]));
                if (out_ready) begin
                    if (verbose)
                        $display("[TB] pop %0d result=0x%08h flags=0x%02h", pops, out_result, out_flags);
                    void'(exp_q.pop_front());
                    retired_m = retired_m + 1'b1;
                    pops++;
                end
            end
        end
    end

    initial begin
        bit acc;
        logic [FW-1:0] dz_nx;
        for (int i = 0; i < FW; i++) hist_m[i] = 0;

        // 1. Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_sticky", 64'(sticky_flags), 64'd0);
        check("rst_retired", 64'(retired_cnt), 64'd0);
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // 2. Single push with consumer ready
        send(32'h3F800000, '0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("one_retired", 64'(retired_cnt), 64'd1);

        // 3. Consumer stalled: third entry held upstream, then order A,B,C
        send(32'hAAAA0001, 5'h01, 1'b0, 1'b0);
        send(32'hBBBB0002, 5'h02, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'hCCCC0003, 5'h04, 1'b0, 1'b0, acc);
        check("held_not_taken", 64'(acc), 64'd0);
        send(32'hCCCC0003, 5'h04, 1'b1, 1'b0);
        drain();

        // 4. Sticky accumulation and clear with simultaneous push
        cycle(1'b0, 32'd0, '0, 1'b1, 1'b1, acc);
        dz_nx = '0;
        dz_nx[F_DIVIDE_BY_ZERO] = 1'b1;
        send(32'h7F800000, fp_flags_t'(1 << F_DIVIDE_BY_ZERO), 1'b1, 1'b0);
        send(32'h3EAAAAAB, fp_flags_t'(1 << F_INEXACT), 1'b1, 1'b0);
        dz_nx[F_INEXACT] = 1'b1;
        check("sticky_dz_nx", 64'(sticky_flags), 64'(dz_nx));
        send(32'h7F800000, fp_flags_t'(1 << F_OVERFLOW), 1'b1, 1'b1);
        check("sticky_clr_of", 64'(sticky_flags), 64'(1 << F_OVERFLOW));
        drain();

        // 5. Full FIFO with pop and push requested on the same edge
        send(32'h11111111, 5'h10, 1'b0, 1'b0);
        send(32'h22222222, 5'h08, 1'b0, 1'b0);
        cycle(1'b1, 32'h33333333, 5'h03, 1'b1, 1'b0, acc);
        check("full_pop_no_push", 64'(acc), 64'd0);
        cycle(1'b1, 32'h33333333, 5'h03, 1'b1, 1'b0, acc);
        check("push_after_full", 64'(acc), 64'd1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, FW'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, acc);
        end
        drain();

        // 6. Reset while two entries are held
        send(32'hDEAD0001, 5'h11, 1'b0, 1'b0);
        send(32'hDEAD0002, 5'h06, 1'b0, 1'b0);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_sticky", 64'(sticky_flags), 64'd0);
        check("arst_retired", 64'(retired_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        sticky_m  = '0;
        retired_m = '0;
        for (int i = 0; i < FW; i++) hist_m[i] = 0;
        for (int n = 0; n < 4; n++) begin
            idle(1'b1);
            check("post_rst_valid", 64'(out_valid), 64'd0);
            check("post_rst_result", 64'(out_result), 64'd0);
        end
        mon_en = 1'b1;

`ifdef FP_FLAG_STATS_EN
        for (int i = 0; i < FW; i++) check("hist_rst", 64'(flag_hist[i*CW +: CW]), 64'd0);
        verbose = 1'b0;
        for (int n = 0; n < 65540; n++) cycle(1'b1, $urandom, 5'h1F, 1'b1, 1'b0, acc);
        verbose = 1'b1;
        for (int i = 0; i < FW; i++) check("hist_sat", 64'(flag_hist[i*CW +: CW]), 64'hFFFF);
        cycle(1'b1, 32'h12345678, 5'h05, 1'b1, 1'b1, acc);
        for (int i = 0; i < FW; i++)
            check("hist_clr_push", 64'(flag_hist[i*CW +: CW]), (i == 0 || i == 2) ? 64'd1 : 64'd0);
        drain();
`endif

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
